// File: rtl/tcp_rx_ctrl.sv
// tcp_rx_ctrl -- receive-side TCP control FSM.
//
// Sequences one parsed header at a time through the receive datapath:
// flow-CAM lookup, flow-ID allocation for new connections, flow-state
// memory read / calculation / write-back, and the new-flow fan-out
// (flow-state init, application notify, SYN-ACK enqueue).
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   rx_hdr_val/rdy, rx_tcp_flags      header handshake and TCP flags
//   read_flow_cam_val/hit             combinational CAM lookup
//   flowid_manager_avail/req          free flow-ID pool
//   ctrl_datap_save_*, store_flowid_* single-cycle datapath strobes
//   state_rd_req_val/rdy, _resp_val   flow-state reads {rx, tx, head, tail}
//   state_wr_req_val/rdy              flow-state writes {rx state, rx tail, tx head}
//   rx_sched_update_val/rdy           scheduler update
//   tcp_rx_dst_val/rdy                payload dispatch notification
//   new_flow_val/rdy                  flow-state init
//   app_new_flow_val/rdy              application notify
//   slow_path_send_pkt_enqueue_val/rdy SYN-ACK enqueue
//   drop_cnt, syn_stall_cnt           saturating statistics
module tcp_rx_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned SYN_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_hdr_val,
  output logic             rx_hdr_rdy,
  input  logic [7:0]       rx_tcp_flags,
  output logic             read_flow_cam_val,
  input  logic             read_flow_cam_hit,
  input  logic             flowid_manager_avail,
  output logic             flowid_manager_req,
  output logic             ctrl_datap_save_input,
  output logic             ctrl_datap_save_flow_state,
  output logic             ctrl_datap_save_calcs,
  output logic             store_flowid_cam,
  output logic             store_flowid_manager,
  output logic             state_rd_req_val,
  input  logic [3:0]       state_rd_req_rdy,
  input  logic [3:0]       state_rd_resp_val,
  output logic [2:0]       state_wr_req_val,
  input  logic [2:0]       state_wr_req_rdy,
  output logic             rx_sched_update_val,
  input  logic             rx_sched_update_rdy,
  output logic             tcp_rx_dst_val,
  input  logic             tcp_rx_dst_rdy,
  output logic             new_flow_val,
  input  logic             new_flow_rdy,
  output logic             app_new_flow_val,
  input  logic             app_new_flow_rdy,
  output logic             slow_path_send_pkt_enqueue_val,
  input  logic             slow_path_send_pkt_enqueue_rdy,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] syn_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_CALC,
    S_WR,
    S_NEW_FLOW
  } state_e;

  // Masking the whole flag byte keeps every flag bit in use.
  localparam logic [7:0] SYN_MASK = 8'(1) << SYN_BIT;

  state_e           state_q, state_d;
  logic [3:0]       rd_acc_q, rd_acc_d;     // read requests accepted
  logic [3:0]       rd_resp_q, rd_resp_d;   // read responses seen
  logic [2:0]       wr_done_q, wr_done_d;
  logic             sched_done_q, sched_done_d;
  logic             dst_done_q, dst_done_d;
  logic [2:0]       nf_done_q, nf_done_d;   // {slow path, app, new flow}
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             drop_inc, stall_inc;
  logic             syn;
  logic [3:0]       rd_acc_all, rd_resp_all;

  assign syn           = |(rx_tcp_flags & SYN_MASK);
  assign rd_acc_all    = rd_acc_q | state_rd_req_rdy;
  assign rd_resp_all   = rd_resp_q | state_rd_resp_val;
  assign drop_cnt      = drop_cnt_q;
  assign syn_stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_acc_q     <= '0;
      rd_resp_q    <= '0;
      wr_done_q    <= '0;
      sched_done_q <= 1'b0;
      dst_done_q   <= 1'b0;
      nf_done_q    <= '0;
      drop_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rd_acc_q     <= rd_acc_d;
      rd_resp_q    <= rd_resp_d;
      wr_done_q    <= wr_done_d;
      sched_done_q <= sched_done_d;
      dst_done_q   <= dst_done_d;
      nf_done_q    <= nf_done_d;
      drop_cnt_q   <= drop_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_acc_d     = rd_acc_q;
    rd_resp_d    = rd_resp_q;
    wr_done_d    = wr_done_q;
    sched_done_d = sched_done_q;
    dst_done_d   = dst_done_q;
    nf_done_d    = nf_done_q;
    drop_inc     = 1'b0;
    stall_inc    = 1'b0;

    rx_hdr_rdy                     = 1'b0;
    read_flow_cam_val              = 1'b0;
    flowid_manager_req             = 1'b0;
    ctrl_datap_save_input          = 1'b0;
    ctrl_datap_save_flow_state     = 1'b0;
    ctrl_datap_save_calcs          = 1'b0;
    store_flowid_cam               = 1'b0;
    store_flowid_manager           = 1'b0;
    state_rd_req_val               = 1'b0;
    state_wr_req_val               = '0;
    rx_sched_update_val            = 1'b0;
    tcp_rx_dst_val                 = 1'b0;
    new_flow_val                   = 1'b0;
    app_new_flow_val               = 1'b0;
    slow_path_send_pkt_enqueue_val = 1'b0;

    // Outputs are held low while reset is asserted so that in-flight
    // handshakes are abandoned in the reset cycle itself.
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_hdr_val) begin
            read_flow_cam_val = 1'b1;
            if (read_flow_cam_hit) begin
              rx_hdr_rdy            = 1'b1;
              ctrl_datap_save_input = 1'b1;
              store_flowid_cam      = 1'b1;
              rd_acc_d              = '0;
              rd_resp_d             = '0;
              state_d               = S_RD_REQ;
            end else if (syn) begin
              if (flowid_manager_avail) begin
                rx_hdr_rdy            = 1'b1;
                ctrl_datap_save_input = 1'b1;
                store_flowid_manager  = 1'b1;
                flowid_manager_req    = 1'b1;
                nf_done_d             = '0;
                state_d               = S_NEW_FLOW;
              end else begin
                stall_inc = 1'b1;
              end
            end else begin
              rx_hdr_rdy = 1'b1;
              drop_inc   = 1'b1;
            end
          end
        end

        S_RD_REQ: begin
          state_rd_req_val = 1'b1;
          rd_acc_d         = rd_acc_all;
          rd_resp_d        = rd_resp_all;
          if (&rd_acc_all) begin
            state_d = S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          // Completion uses the live response bits so the strobe fires in
          // the same cycle the final response arrives.
          if (&rd_resp_all) begin
            ctrl_datap_save_flow_state = 1'b1;
            rd_acc_d                   = '0;
            rd_resp_d                  = '0;
            state_d                    = S_CALC;
          end else begin
            rd_resp_d = rd_resp_all;
          end
        end

        S_CALC: begin
          ctrl_datap_save_calcs = 1'b1;
          wr_done_d             = '0;
          sched_done_d          = 1'b0;
          dst_done_d            = 1'b0;
          state_d               = S_WR;
        end

        S_WR: begin
          state_wr_req_val    = ~wr_done_q;
          rx_sched_update_val = ~sched_done_q;
          tcp_rx_dst_val      = ~dst_done_q;
          // valid is the inverse of done, so done|rdy == done|(val&rdy).
          wr_done_d    = wr_done_q | state_wr_req_rdy;
          sched_done_d = sched_done_q | rx_sched_update_rdy;
          dst_done_d   = dst_done_q | tcp_rx_dst_rdy;
          if ((&wr_done_d) && sched_done_d && dst_done_d) begin
            wr_done_d    = '0;
            sched_done_d = 1'b0;
            dst_done_d   = 1'b0;
            state_d      = S_IDLE;
          end
        end

        S_NEW_FLOW: begin
          new_flow_val                   = ~nf_done_q[0];
          app_new_flow_val               = ~nf_done_q[1];
          slow_path_send_pkt_enqueue_val = ~nf_done_q[2];
          nf_done_d = nf_done_q | {slow_path_send_pkt_enqueue_rdy,
                                   app_new_flow_rdy, new_flow_rdy};
          if (&nf_done_d) begin
            nf_done_d = '0;
            state_d   = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (drop_inc && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

endmodule
